// File: rtl/custom_ip_mc.sv
// Multi-channel register-controlled compute engine: NUM_CH independent fixed-latency ALU channels.
// Optional CUSTOM_IP_ABORT_EN adds a per-channel abort input and a sticky aborted flag.
module custom_ip_mc #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned MAX_LAT    = 15,
    parameter int unsigned LAT_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            start,
    input  logic [2*NUM_CH-1:0]          op_sel,
    input  logic [LAT_W*NUM_CH-1:0]      lat_cfg,
    input  logic [DATA_WIDTH*NUM_CH-1:0] data_a,
    input  logic [DATA_WIDTH*NUM_CH-1:0] data_b,
    input  logic [NUM_CH-1:0]            done_clr,
    input  logic [NUM_CH-1:0]            irq_mask,
`ifdef CUSTOM_IP_ABORT_EN
    input  logic [NUM_CH-1:0]            abort,
    output logic [NUM_CH-1:0]            aborted,
`endif
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH-1:0]            done,
    output logic [NUM_CH-1:0]            err_ovr,
    output logic [DATA_WIDTH*NUM_CH-1:0] result,
    output logic                         irq
);

    localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic [NUM_CH-1:0] done_d;
    logic              irq_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e                  state_q, state_d;
        logic [CNT_W-1:0]        cnt_q, cnt_d;
        logic [CNT_W-1:0]        lat_q, lat_d;
        logic [CNT_W-1:0]        eff_lat;
        logic [1:0]              op_q, op_d;
        logic [DATA_WIDTH-1:0]   a_q, a_d;
        logic [DATA_WIDTH-1:0]   b_q, b_d;
        logic [DATA_WIDTH-1:0]   res_q, res_d;
        logic [DATA_WIDTH-1:0]   alu;
        logic                    done_q, done_nxt;
        logic                    err_q, err_d;
        logic                    last;
        logic                    abort_hit;
        logic [LAT_W-1:0]        lat_in;

        assign lat_in = lat_cfg[c*LAT_W +: LAT_W];
        assign last   = (cnt_q == lat_q - CNT_W'(1));

`ifdef CUSTOM_IP_ABORT_EN
        logic aborted_q, aborted_d;
        assign abort_hit  = abort[c];
        assign aborted[c] = aborted_q;
`else
        assign abort_hit = 1'b0;
`endif

        // Zero latency runs as one cycle; oversize requests clamp to MAX_LAT.
        always_comb begin
            eff_lat = CNT_W'(lat_in);
            if (lat_in == '0) begin
                eff_lat = CNT_W'(1);
            end else if (32'(lat_in) > MAX_LAT) begin
                eff_lat = CNT_W'(MAX_LAT);
            end
        end

        always_comb begin
            case (op_q)
                OP_ADD:  alu = a_q + b_q;
                OP_SUB:  alu = a_q - b_q;
                OP_XOR:  alu = a_q ^ b_q;
                default: alu = a_q + DATA_WIDTH'(16);
            endcase
        end

        // State register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Next-state logic
        always_comb begin
            state_d = state_q;
            case (state_q)
                S_IDLE:  if (start[c]) state_d = S_RUN;
                S_RUN:   if (abort_hit || last) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Datapath and sticky flag next values; a set in the same cycle beats a clear.
        always_comb begin
            cnt_d    = cnt_q;
            lat_d    = lat_q;
            op_d     = op_q;
            a_d      = a_q;
            b_d      = b_q;
            res_d    = res_q;
            done_nxt = done_q;
            err_d    = err_q;
`ifdef CUSTOM_IP_ABORT_EN
            aborted_d = aborted_q;
            if (done_clr[c]) aborted_d = 1'b0;
`endif
            if (done_clr[c]) begin
                done_nxt = 1'b0;
                err_d    = 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (start[c]) begin
                        cnt_d = '0;
                        lat_d = eff_lat;
                        op_d  = op_sel[c*2 +: 2];
                        a_d   = data_a[c*DATA_WIDTH +: DATA_WIDTH];
                        b_d   = data_b[c*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                S_RUN: begin
                    if (start[c]) err_d = 1'b1;
                    if (abort_hit) begin
                        cnt_d = '0;
`ifdef CUSTOM_IP_ABORT_EN
                        aborted_d = 1'b1;
`endif
                    end else if (last) begin
                        cnt_d    = '0;
                        res_d    = alu;
                        done_nxt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                lat_q  <= '0;
                op_q   <= '0;
                a_q    <= '0;
                b_q    <= '0;
                res_q  <= '0;
                done_q <= 1'b0;
                err_q  <= 1'b0;
`ifdef CUSTOM_IP_ABORT_EN
                aborted_q <= 1'b0;
`endif
            end else begin
                cnt_q  <= cnt_d;
                lat_q  <= lat_d;
                op_q   <= op_d;
                a_q    <= a_d;
                b_q    <= b_d;
                res_q  <= res_d;
                done_q <= done_nxt;
                err_q  <= err_d;
`ifdef CUSTOM_IP_ABORT_EN
                aborted_q <= aborted_d;
`endif
            end
        end

        assign done_d[c]                             = done_nxt;
        assign busy[c]                               = (state_q == S_RUN);
        assign done[c]                               = done_q;
        assign err_ovr[c]                            = err_q;
        assign result[c*DATA_WIDTH +: DATA_WIDTH]    = res_q;
    end

    // irq tracks the done value being written this edge, gated by the current mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(done_d & irq_mask);
        end
    end

    assign irq = irq_q;

endmodule
